// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared AER transmitter types and address-width helper
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } aer_state_e;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aer_sync.sv
// rtl/aer_sync.sv - multi-flop synchroniser for an asynchronous single-bit input
module aer_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/aer_tx_rr.sv
// rtl/aer_tx_rr.sv - round-robin AER four-phase transmitter with overrun drop counter
module aer_tx_rr
    import aer_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int DROP_W      = 8,
    localparam int ADDR_W      = addr_w(N_CH)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [N_CH-1:0]   ev_i,
    output logic [N_CH-1:0]   senack_o,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              ack_i,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int CNT_W = $clog2(N_CH + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    aer_state_e        state_q, state_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   senack_q, senack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_grant_q, last_grant_d;
    logic              req_q, req_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ack_s;

    logic [N_CH-1:0]   drop_vec;
    logic [CNT_W-1:0]  drop_num;
    logic [SUM_W-1:0]  drop_sum;
    logic [ADDR_W-1:0] grant;
    logic              grant_vld;
    int                rr_idx;

    aer_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (ack_i),
        .q_o      (ack_s)
    );

    // The pending clear coincides with the visible senack pulse, so an event
    // arriving in that same cycle re-arms the channel instead of being dropped.
    always_comb begin
        drop_vec  = ev_i & pending_q & ~senack_q;
        pending_d = (pending_q & ~senack_q) | ev_i;
        drop_num  = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_num = drop_num + CNT_W'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(drop_num);
        drop_d   = (|drop_sum[SUM_W-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
    end

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = 0;
        for (int k = 1; k <= N_CH; k++) begin
            rr_idx = (int'(last_grant_q) + k) % N_CH;
            if (!grant_vld && pending_q[rr_idx]) begin
                grant     = ADDR_W'(rr_idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        senack_d     = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    addr_d       = grant;
                    last_grant_d = grant;
                    req_d        = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d    = 1'b0;
                    senack_d = N_CH'(1) << addr_q;
                    state_d  = REL;
                end
            end
            REL: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            senack_q     <= '0;
            addr_q       <= '0;
            last_grant_q <= ADDR_W'(N_CH - 1);
            req_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            senack_q     <= senack_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            drop_q       <= drop_d;
        end
    end

    assign senack_o   = senack_q;
    assign req_o      = req_q;
    assign addr_o     = addr_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_aer_tx_rr.sv
// tb/tb_aer_tx_rr.sv - scoreboard bench for the round-robin AER transmitter
module tb_aer_tx_rr;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [3:0] ev_i;
    logic [3:0] senack_o;
    logic       req_o;
    logic [1:0] addr_o;
    logic       ack_i;
    logic [7:0] drop_cnt_o;

    logic [3:0] ev2_i;
    logic [3:0] senack2_o;
    logic       req2_o;
    logic [1:0] addr2_o;
    logic       ack2_i;
    logic [1:0] drop2_o;

    logic ack_rcv;
    logic ack_force;
    logic rcv_en;
    assign ack_i  = ack_rcv | ack_force;
    assign ack2_i = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   senack_cnt = 0;
    int   base_cnt;
    logic req_prev = 1'b0;
    logic [1:0] rise_addr = '0;

    always #5 clk_i = ~clk_i;

    aer_tx_rr #(.N_CH(4), .SYNC_STAGES(2), .DROP_W(8)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .ev_i       (ev_i),
        .senack_o   (senack_o),
        .req_o      (req_o),
        .addr_o     (addr_o),
        .ack_i      (ack_i),
        .drop_cnt_o (drop_cnt_o)
    );

    aer_tx_rr #(.N_CH(4), .SYNC_STAGES(2), .DROP_W(2)) dut_sat (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .ev_i       (ev2_i),
        .senack_o   (senack2_o),
        .req_o      (req2_o),
        .addr_o     (addr2_o),
        .ack_i      (ack2_i),
        .drop_cnt_o (drop2_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver: acks a few cycles after req, releases once req drops.
    initial begin
        ack_rcv = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rcv_en && req_o && !ack_rcv) begin
                repeat (3) @(posedge clk_i);
                #1 ack_rcv = 1'b1;
                for (int k = 0; k < 50 && req_o; k++) begin
                    @(posedge clk_i);
                    #1;
                end
                ack_rcv = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (req_o && !req_prev) rise_addr = addr_o;
            if (senack_o != 4'b0) begin
                int idx;
                idx = 0;
                for (int i = 0; i < 4; i++) if (senack_o[i]) idx = i;
                senack_cnt++;
                chk("senack_onehot", 32'($onehot(senack_o)), 1);
                chk("senack_matches_addr", idx, addr_o);
                chk("addr_stable", addr_o, rise_addr);
                chk("req_low_at_senack", req_o, 0);
                if (exp_q.size() == 0) begin
                    chk("senack_unexpected", idx, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_addr", idx, exp_q.pop_front());
                end
            end
            req_prev = req_o;
        end else begin
            req_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        ev_i = v;
        step();
        ev_i = 4'b0;
    endtask

    task automatic pulse2(input logic [3:0] v);
        ev2_i = v;
        step();
        ev2_i = 4'b0;
    endtask

    task automatic do_reset();
        reset_ni  = 1'b0;
        ev_i      = 4'b0;
        ev2_i     = 4'b0;
        ack_force = 1'b0;
        exp_q.delete();
        repeat (3) step();
        reset_ni = 1'b1;
        step();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || req_o || ack_i) && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_drain_timeout"}, 32'(k < 300), 1);
        repeat (3) step();
    endtask

    initial begin
        reset_ni  = 1'b0;
        ev_i      = 4'b0;
        ev2_i     = 4'b0;
        ack_force = 1'b0;
        rcv_en    = 1'b0;
        #2;
        chk("rst_req", req_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_senack", senack_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        do_reset();
        rcv_en = 1'b1;

        // single event on channel 0: two-cycle latency, one senack pulse
        base_cnt = senack_cnt;
        exp_q.push_back(0);
        pulse(4'b0001);
        chk("lat_t1_req", req_o, 0);
        step();
        chk("lat_t2_req", req_o, 1);
        chk("lat_t2_addr", addr_o, 0);
        begin
            int k;
            k = 0;
            while (senack_o == 4'b0 && k < 50) begin step(); k++; end
            chk("single_senack", senack_o, 4'b0001);
            step();
            chk("single_senack_once", senack_o, 4'b0000);
            chk("single_req_low", req_o, 0);
        end
        drain("single");
        chk("single_count", senack_cnt - base_cnt, 1);

        // all channels at once, from reset priority
        do_reset();
        base_cnt = senack_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        pulse(4'b1111);
        drain("all4");
        chk("all4_count", senack_cnt - base_cnt, 4);
        chk("all4_drop", drop_cnt_o, 0);

        // overrun on channel 2 while it waits for its transfer
        base_cnt = senack_cnt;
        exp_q.push_back(2);
        pulse(4'b0100);
        step();
        pulse(4'b0100);
        drain("overrun");
        chk("overrun_count", senack_cnt - base_cnt, 1);
        chk("overrun_drop", drop_cnt_o, 1);

        // re-arm in the senack cycle is not an overrun
        base_cnt = senack_cnt;
        exp_q.push_back(1);
        exp_q.push_back(1);
        pulse(4'b0010);
        begin
            int k;
            k = 0;
            while (!senack_o[1] && k < 50) begin step(); k++; end
            chk("rearm_seen", senack_o[1], 1);
            pulse(4'b0010);
        end
        drain("rearm");
        chk("rearm_count", senack_cnt - base_cnt, 2);
        chk("rearm_drop", drop_cnt_o, 1);

        // reset in the middle of a handshake
        rcv_en   = 1'b0;
        base_cnt = senack_cnt;
        pulse(4'b1000);
        begin
            int k;
            k = 0;
            while (!req_o && k < 20) begin step(); k++; end
            chk("abort_req_up", req_o, 1);
        end
        ack_force = 1'b1;
        step();
        reset_ni = 1'b0;
        #1;
        chk("abort_req", req_o, 0);
        chk("abort_senack", senack_o, 0);
        chk("abort_addr", addr_o, 0);
        repeat (2) step();
        ack_force = 1'b0;
        repeat (2) step();
        reset_ni = 1'b1;
        repeat (12) step();
        chk("abort_idle_req", req_o, 0);
        chk("abort_no_senack", senack_cnt - base_cnt, 0);
        chk("abort_drop", drop_cnt_o, 0);

        // saturating counter on the narrow instance
        pulse2(4'b0011);
        step();
        pulse2(4'b0011);
        step();
        chk("sat_two_drops", drop2_o, 2);
        pulse2(4'b0001);
        step();
        chk("sat_three_drops", drop2_o, 3);
        pulse2(4'b0001);
        pulse2(4'b0001);
        step();
        chk("sat_hold", drop2_o, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
